wb_regfile: RTL and testbench

Architectural state block at the far end of the writeback interface. It takes the writeback stage's GPR write (destination, enable, data) and HI/LO write (enable, hi, lo) and commits them on the clock edge. It serves two combinational GPR read ports and the HI/LO read values to the decode and execute stages. It holds 31 writable 32-bit GPRs (register 0 hardwired to zero) plus the HI and LO registers.

---
 rtl/wb_regfile_if.sv | 34 +++
 rtl/wb_regfile.sv | 92 +++++++++
 tb/tb_wb_regfile.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/wb_regfile_if.sv
// wb_regfile_if: writeback/read bundle between the pipeline and the
// architectural register file. The pipeline side (writeback, decode and
// execute) uses the master modport; the register file uses the slave
// modport.
interface wb_regfile_if;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        re1;
    logic [4:0]  raddr1;
    logic [31:0] rdata1;
    logic        re2;
    logic [4:0]  raddr2;
    logic [31:0] rdata2;
    logic        whilo;
    logic [31:0] hi_i;
    logic [31:0] lo_i;
    logic [31:0] hi_o;
    logic [31:0] lo_o;

    modport master (
        output we, waddr, wdata,
        output re1, raddr1, re2, raddr2,
        output whilo, hi_i, lo_i,
        input  rdata1, rdata2, hi_o, lo_o
    );

    modport slave (
        input  we, waddr, wdata,
        input  re1, raddr1, re2, raddr2,
        input  whilo, hi_i, lo_i,
        output rdata1, rdata2, hi_o, lo_o
    );
endinterface

// File: rtl/wb_regfile.sv
// wb_regfile: 31 writable 32-bit GPRs (r0 reads as zero) plus HI/LO.
// Writes commit on the rising clock edge. Reads are combinational.
// rst is asynchronous and active-low. While it is low, all state is
// cleared and all outputs read as zero.
// Optional macro WB_BYPASS_EN: reads forward same-cycle write data
// (wdata, hi_i and lo_i). This closes the writeback-to-decode hazard.
module wb_regfile (
    input  logic         clk,
    input  logic         rst,
    wb_regfile_if.slave  bus
);

    logic [31:0] r_gpr [1:31];
    logic [31:0] r_hi;
    logic [31:0] r_lo;

    logic [31:0] w_rdata1;
    logic [31:0] w_rdata2;
    logic [31:0] w_hi;
    logic [31:0] w_lo;

    // Commit GPR and HI/LO writes on the edge. Async clear when rst is low.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 1; i < 32; i++) begin
                r_gpr[i] <= '0;
            end
            r_hi <= '0;
            r_lo <= '0;
        end else begin
            if (bus.we && (bus.waddr != 5'd0)) begin
                r_gpr[bus.waddr] <= bus.wdata;
            end
            if (bus.whilo) begin
                r_hi <= bus.hi_i;
                r_lo <= bus.lo_i;
            end
        end
    end

    // Read port 1: reset, disable and r0 force zero, then bypass, then storage.
    always_comb begin
        w_rdata1 = '0;
        if (!rst || !bus.re1 || (bus.raddr1 == 5'd0)) begin
            w_rdata1 = '0;
`ifdef WB_BYPASS_EN
        end else if (bus.we && (bus.waddr == bus.raddr1)) begin
            w_rdata1 = bus.wdata;
`endif
        end else begin
            w_rdata1 = r_gpr[bus.raddr1];
        end
    end

    // Read port 2: same priority as port 1, fully independent of it.
    always_comb begin
        w_rdata2 = '0;
        if (!rst || !bus.re2 || (bus.raddr2 == 5'd0)) begin
            w_rdata2 = '0;
`ifdef WB_BYPASS_EN
        end else if (bus.we && (bus.waddr == bus.raddr2)) begin
            w_rdata2 = bus.wdata;
`endif
        end else begin
            w_rdata2 = r_gpr[bus.raddr2];
        end
    end

    // HI/LO read: zero in reset, otherwise stored (or forwarded) value.
    always_comb begin
        w_hi = '0;
        w_lo = '0;
        if (!rst) begin
            w_hi = '0;
            w_lo = '0;
`ifdef WB_BYPASS_EN
        end else if (bus.whilo) begin
            w_hi = bus.hi_i;
            w_lo = bus.lo_i;
`endif
        end else begin
            w_hi = r_hi;
            w_lo = r_lo;
        end
    end

    assign bus.rdata1 = w_rdata1;
    assign bus.rdata2 = w_rdata2;
    assign bus.hi_o   = w_hi;
    assign bus.lo_o   = w_lo;

endmodule

// File: tb/tb_wb_regfile.sv
module tb_wb_regfile;

  logic clk;
  logic rst;

  wb_regfile_if bus();

  wb_regfile dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks;
  int failures;

`ifdef WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    checks     = 0;
    failures   = 0;
    rst        = 1'b0;
    bus.we     = 1'b0;
    bus.waddr  = 5'd0;
    bus.wdata  = 32'h0;
    bus.re1    = 1'b1;
    bus.raddr1 = 5'd5;
    bus.re2    = 1'b0;
    bus.raddr2 = 5'd0;
    bus.whilo  = 1'b0;
    bus.hi_i   = 32'h0;
    bus.lo_i   = 32'h0;

    cyc();
    #2;
    checks++;
    if (bus.rdata1 !== 32'h0) begin failures++; $display("FAIL reset_rdata1: got 0x%08h expected 0x%08h", bus.rdata1, 32'h0); end
    checks++;
    if (bus.hi_o !== 32'h0) begin failures++; $display("FAIL reset_hi: got 0x%08h expected 0x%08h", bus.hi_o, 32'h0); end
    checks++;
    if (bus.lo_o !== 32'h0) begin failures++; $display("FAIL reset_lo: got 0x%08h expected 0x%08h", bus.lo_o, 32'h0); end

    cyc();
    rst       = 1'b1;
    bus.we    = 1'b1;
    bus.waddr = 5'd5;
    bus.wdata = 32'h1234_5678;
    bus.whilo = 1'b1;
    bus.hi_i  = 32'hAAAA_0000;
    bus.lo_i  = 32'h0000_00BB;
    cyc();
    bus.we    = 1'b0;
    bus.whilo = 1'b0;
    #2;
    checks++;
    if (bus.rdata1 !== 32'h1234_5678) begin failures++; $display("FAIL pre_reset_gpr5: got 0x%08h expected 0x%08h", bus.rdata1, 32'h1234_5678); end
    checks++;
    if (bus.hi_o !== 32'hAAAA_0000) begin failures++; $display("FAIL pre_reset_hi: got 0x%08h expected 0x%08h", bus.hi_o, 32'hAAAA_0000); end

    cyc();
    rst = 1'b0;
    #1;
    checks++;
    if (bus.rdata1 !== 32'h0) begin failures++; $display("FAIL async_low_gpr5: got 0x%08h expected 0x%08h", bus.rdata1, 32'h0); end
    checks++;
    if (bus.hi_o !== 32'h0) begin failures++; $display("FAIL async_low_hi: got 0x%08h expected 0x%08h", bus.hi_o, 32'h0); end
    #1;
    rst = 1'b1;
    #1;
    checks++;
    if (bus.rdata1 !== 32'h0) begin failures++; $display("FAIL async_clear_gpr5: got 0x%08h expected 0x%08h", bus.rdata1, 32'h0); end
    checks++;
    if (bus.hi_o !== 32'h0) begin failures++; $display("FAIL async_clear_hi: got 0x%08h expected 0x%08h", bus.hi_o, 32'h0); end
    checks++;
    if (bus.lo_o !== 32'h0) begin failures++; $display("FAIL async_clear_lo: got 0x%08h expected 0x%08h", bus.lo_o, 32'h0); end

    cyc();
    bus.we    = 1'b1;
    bus.waddr = 5'd7;
    bus.wdata = 32'hDEAD_BEEF;
    cyc();
    bus.we     = 1'b0;
    bus.raddr1 = 5'd7;
    bus.re2    = 1'b1;
    bus.raddr2 = 5'd7;
    #2;
    checks++;
    if (bus.rdata1 !== 32'hDEAD_BEEF) begin failures++; $display("FAIL basic_r1: got 0x%08h expected 0x%08h", bus.rdata1, 32'hDEAD_BEEF); end
    checks++;
    if (bus.rdata2 !== 32'hDEAD_BEEF) begin failures++; $display("FAIL basic_r2: got 0x%08h expected 0x%08h", bus.rdata2, 32'hDEAD_BEEF); end
    cyc();
    bus.re1 = 1'b0;
    #2;
    checks++;
    if (bus.rdata1 !== 32'h0) begin failures++; $display("FAIL disabled_r1: got 0x%08h expected 0x%08h", bus.rdata1, 32'h0); end
    checks++;
    if (bus.rdata2 !== 32'hDEAD_BEEF) begin failures++; $display("FAIL basic_r2_hold: got 0x%08h expected 0x%08h", bus.rdata2, 32'hDEAD_BEEF); end

    cyc();
    bus.re1    = 1'b1;
    bus.raddr1 = 5'd0;
    bus.we     = 1'b1;
    bus.waddr  = 5'd0;
    bus.wdata  = 32'hFFFF_FFFF;
    #2;
    checks++;
    if (bus.rdata1 !== 32'h0) begin failures++; $display("FAIL r0_same_cycle: got 0x%08h expected 0x%08h", bus.rdata1, 32'h0); end
    cyc();
    bus.we = 1'b0;
    #2;
    checks++;
    if (bus.rdata1 !== 32'h0) begin failures++; $display("FAIL r0_after_write: got 0x%08h expected 0x%08h", bus.rdata1, 32'h0); end

    cyc();
    bus.we    = 1'b1;
    bus.waddr = 5'd9;
    bus.wdata = 32'h0000_0011;
    cyc();
    bus.we     = 1'b0;
    bus.wdata  = 32'h5555_5555;
    bus.raddr1 = 5'd9;
    #2;
    checks++;
    if (bus.rdata1 !== 32'h0000_0011) begin failures++; $display("FAIL bubble_same_cycle: got 0x%08h expected 0x%08h", bus.rdata1, 32'h0000_0011); end
    cyc();
    #2;
    checks++;
    if (bus.rdata1 !== 32'h0000_0011) begin failures++; $display("FAIL bubble_after_edge: got 0x%08h expected 0x%08h", bus.rdata1, 32'h0000_0011); end

    cyc();
    bus.we    = 1'b1;
    bus.waddr = 5'd3;
    bus.wdata = 32'h0000_0033;
    cyc();
    bus.wdata  = 32'hCAFE_F00D;
    bus.raddr1 = 5'd3;
    bus.raddr2 = 5'd3;
    #2;
    checks++;
    if (bus.rdata1 !== (BYP ? 32'hCAFE_F00D : 32'h0000_0033)) begin failures++; $display("FAIL bypass_r1: got 0x%08h", bus.rdata1); end
    checks++;
    if (bus.rdata2 !== (BYP ? 32'hCAFE_F00D : 32'h0000_0033)) begin failures++; $display("FAIL bypass_r2: got 0x%08h", bus.rdata2); end
    cyc();
    bus.we = 1'b0;
    #2;
    checks++;
    if (bus.rdata1 !== 32'hCAFE_F00D) begin failures++; $display("FAIL write_visible_next: got 0x%08h expected 0x%08h", bus.rdata1, 32'hCAFE_F00D); end

    cyc();
    bus.whilo = 1'b1;
    bus.hi_i  = 32'h0000_0001;
    bus.lo_i  = 32'h0000_0002;
    bus.we    = 1'b1;
    bus.waddr = 5'd4;
    bus.wdata = 32'h4444_4444;
    #2;
    checks++;
    if (bus.hi_o !== (BYP ? 32'h0000_0001 : 32'h0)) begin failures++; $display("FAIL hilo_same_cycle_hi: got 0x%08h", bus.hi_o); end
    checks++;
    if (bus.lo_o !== (BYP ? 32'h0000_0002 : 32'h0)) begin failures++; $display("FAIL hilo_same_cycle_lo: got 0x%08h", bus.lo_o); end
    cyc();
    bus.whilo  = 1'b0;
    bus.hi_i   = 32'h0000_0099;
    bus.lo_i   = 32'h0000_0098;
    bus.we     = 1'b0;
    bus.raddr2 = 5'd4;
    #2;
    checks++;
    if (bus.hi_o !== 32'h0000_0001) begin failures++; $display("FAIL hilo_hi: got 0x%08h expected 0x%08h", bus.hi_o, 32'h0000_0001); end
    checks++;
    if (bus.lo_o !== 32'h0000_0002) begin failures++; $display("FAIL hilo_lo: got 0x%08h expected 0x%08h", bus.lo_o, 32'h0000_0002); end
    checks++;
    if (bus.rdata2 !== 32'h4444_4444) begin failures++; $display("FAIL hilo_gpr4: got 0x%08h expected 0x%08h", bus.rdata2, 32'h4444_4444); end
    cyc();
    #2;
    checks++;
    if (bus.hi_o !== 32'h0000_0001) begin failures++; $display("FAIL hilo_no_write_hi: got 0x%08h expected 0x%08h", bus.hi_o, 32'h0000_0001); end
    checks++;
    if (bus.lo_o !== 32'h0000_0002) begin failures++; $display("FAIL hilo_no_write_lo: got 0x%08h expected 0x%08h", bus.lo_o, 32'h0000_0002); end

    cyc();
    bus.we    = 1'b1;
    bus.waddr = 5'd10;
    bus.wdata = 32'h0000_000A;
    cyc();
    bus.wdata = 32'h0000_000B;
    cyc();
    bus.we     = 1'b0;
    bus.raddr1 = 5'd10;
    bus.raddr2 = 5'd7;
    #2;
    checks++;
    if (bus.rdata1 !== 32'h0000_000B) begin failures++; $display("FAIL b2b_last_wins: got 0x%08h expected 0x%08h", bus.rdata1, 32'h0000_000B); end
    checks++;
    if (bus.rdata2 !== 32'hDEAD_BEEF) begin failures++; $display("FAIL independent_r2: got 0x%08h expected 0x%08h", bus.rdata2, 32'hDEAD_BEEF); end

    cyc();
    bus.we    = 1'b1;
    bus.waddr = 5'd31;
    bus.wdata = 32'h3131_3131;
    cyc();
    bus.we     = 1'b0;
    bus.raddr1 = 5'd31;
    #2;
    checks++;
    if (bus.rdata1 !== 32'h3131_3131) begin failures++; $display("FAIL gpr31: got 0x%08h expected 0x%08h", bus.rdata1, 32'h3131_3131); end

    cyc();
    rst = 1'b0;
    #2;
    checks++;
    if (bus.rdata1 !== 32'h0) begin failures++; $display("FAIL held_reset_r1: got 0x%08h expected 0x%08h", bus.rdata1, 32'h0); end
    checks++;
    if (bus.rdata2 !== 32'h0) begin failures++; $display("FAIL held_reset_r2: got 0x%08h expected 0x%08h", bus.rdata2, 32'h0); end
    checks++;
    if (bus.hi_o !== 32'h0) begin failures++; $display("FAIL held_reset_hi: got 0x%08h expected 0x%08h", bus.hi_o, 32'h0); end
    checks++;
    if (bus.lo_o !== 32'h0) begin failures++; $display("FAIL held_reset_lo: got 0x%08h expected 0x%08h", bus.lo_o, 32'h0); end

    cyc();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
